nec_ir_frame_decoder: RTL



---
 rtl/nec_ir_frame_decoder.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/nec_ir_frame_decoder.sv
// NEC IR protocol decoder: turns edge/delay events from the edge catcher into
// address/command frames and repeat codes on a one-entry valid/ready output.
module nec_ir_frame_decoder #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             strict_addr,
    input  logic             ev_new,
    input  logic             ev_type,
    input  logic [DBITS-1:0] ev_delay,
    input  logic             ev_timeout,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [15:0]      frame_addr,
    output logic [7:0]       frame_cmd,
    output logic             frame_repeat,
    output logic             err_pulse,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LSPACE = 3'd1,
        DMARK  = 3'd2,
        DSPACE = 3'd3,
        STOP   = 3'd4,
        RSTOP  = 3'd5
    } state_t;

    function automatic logic in_win(input logic [DBITS-1:0] d, input int unsigned lo, input int unsigned hi);
        return (d >= DBITS'(lo)) && (d <= DBITS'(hi));
    endfunction

    function automatic logic is_compl(input logic [7:0] a, input logic [7:0] b);
        return a == ~b;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] data_q, data_d;
    logic [15:0] last_addr_q, last_addr_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic        have_last_q, have_last_d;
    logic        fv_q, fv_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        rpt_q, rpt_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;

    logic        lead_mark_s, lead_space_s, rpt_space_s, bit_mark_s, zero_space_s, one_space_s;
    logic        frame_ok_s, fault_s, deliver_s, del_rpt_s;
    logic [15:0] del_addr_s, frame_addr_s;
    logic [7:0]  del_cmd_s;

    // Timing window classification of the incoming event delay
    always_comb begin
        lead_mark_s  = in_win(ev_delay, 112, 143);
        lead_space_s = in_win(ev_delay, 56, 71);
        rpt_space_s  = in_win(ev_delay, 28, 35);
        bit_mark_s   = in_win(ev_delay, 6, 11);
        zero_space_s = in_win(ev_delay, 6, 11);
        one_space_s  = in_win(ev_delay, 20, 27);
        frame_ok_s   = is_compl(data_q[31:24], data_q[23:16]) &&
                       (!strict_addr || is_compl(data_q[15:8], data_q[7:0]));
        if (strict_addr) begin
            frame_addr_s = {8'h00, data_q[7:0]};
        end else begin
            frame_addr_s = data_q[15:0];
        end
    end

    // Protocol FSM: next state, bit assembly and frame completion
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        last_addr_d = last_addr_q;
        last_cmd_d  = last_cmd_q;
        have_last_d = have_last_q;
        err_d       = 1'b0;
        fault_s     = 1'b0;
        deliver_s   = 1'b0;
        del_rpt_s   = 1'b0;
        del_addr_s  = 16'h0000;
        del_cmd_s   = 8'h00;
        if (!enable) begin
            state_d = IDLE;
        end else if (ev_new) begin
            case (state_q)
                IDLE: begin
                    if (!ev_timeout && ev_type && lead_mark_s) begin
                        state_d = LSPACE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LSPACE: begin
                    if (ev_timeout || ev_type) begin
                        fault_s = 1'b1;
                    end else if (lead_space_s) begin
                        state_d   = DMARK;
                        bit_cnt_d = 5'd0;
                    end else if (rpt_space_s) begin
                        state_d = RSTOP;
                    end else begin
                        fault_s = 1'b1;
                    end
                end
                DMARK: begin
                    if (!ev_timeout && ev_type && bit_mark_s) begin
                        state_d = DSPACE;
                    end else begin
                        fault_s = 1'b1;
                    end
                end
                DSPACE: begin
                    if (ev_timeout || ev_type || !(zero_space_s || one_space_s)) begin
                        fault_s = 1'b1;
                    end else begin
                        data_d[bit_cnt_q] = one_space_s;
                        if (bit_cnt_q == 5'd31) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            state_d   = DMARK;
                        end
                    end
                end
                STOP: begin
                    if (!ev_timeout && ev_type && bit_mark_s && frame_ok_s) begin
                        state_d     = IDLE;
                        deliver_s   = 1'b1;
                        del_addr_s  = frame_addr_s;
                        del_cmd_s   = data_q[23:16];
                        last_addr_d = frame_addr_s;
                        last_cmd_d  = data_q[23:16];
                        have_last_d = 1'b1;
                    end else begin
                        fault_s = 1'b1;
                    end
                end
                RSTOP: begin
                    if (!ev_timeout && ev_type && bit_mark_s && have_last_q) begin
                        state_d    = IDLE;
                        deliver_s  = 1'b1;
                        del_rpt_s  = 1'b1;
                        del_addr_s = last_addr_q;
                        del_cmd_s  = last_cmd_q;
                    end else begin
                        fault_s = 1'b1;
                    end
                end
                default: begin
                    fault_s = 1'b1;
                end
            endcase
            // A leader-length mark seen in error is treated as the start of a new frame
            if (fault_s) begin
                err_d = 1'b1;
                if (ev_type && lead_mark_s) begin
                    state_d = LSPACE;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                err_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // One-entry output buffer with valid/ready handshake and overrun flag
    always_comb begin
        fv_d   = fv_q;
        addr_d = addr_q;
        cmd_d  = cmd_q;
        rpt_d  = rpt_q;
        ovr_d  = ovr_q;
        busy_d = (state_d != IDLE);
        if (fv_q && frame_ready) begin
            fv_d = 1'b0;
        end else begin
            fv_d = fv_q;
        end
        if (deliver_s) begin
            if (fv_q && !frame_ready) begin
                ovr_d = 1'b1;
            end else begin
                fv_d   = 1'b1;
                addr_d = del_addr_s;
                cmd_d  = del_cmd_s;
                rpt_d  = del_rpt_s;
            end
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and output registers; clear_n acts as a synchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            data_q      <= 32'h0000_0000;
            last_addr_q <= 16'h0000;
            last_cmd_q  <= 8'h00;
            have_last_q <= 1'b0;
            fv_q        <= 1'b0;
            addr_q      <= 16'h0000;
            cmd_q       <= 8'h00;
            rpt_q       <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (!clear_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            data_q      <= 32'h0000_0000;
            last_addr_q <= 16'h0000;
            last_cmd_q  <= 8'h00;
            have_last_q <= 1'b0;
            fv_q        <= 1'b0;
            addr_q      <= 16'h0000;
            cmd_q       <= 8'h00;
            rpt_q       <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            last_cmd_q  <= last_cmd_d;
            have_last_q <= have_last_d;
            fv_q        <= fv_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            rpt_q       <= rpt_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
        end
    end

    assign frame_valid  = fv_q;
    assign frame_addr   = addr_q;
    assign frame_cmd    = cmd_q;
    assign frame_repeat = rpt_q;
    assign err_pulse    = err_q;
    assign overrun      = ovr_q;
    assign busy         = busy_q;

endmodule
